// File: rtl/axi_wr_arbiter.sv
// 2:1 AXI write-channel arbiter: round-robin AW grant, W routed in AW-grant order, B routed by ID MSB.
// Optional macro ARB_LEN_CHECK_EN adds per-burst beat counting with a sticky len_err flag.
module axi_wr_arbiter #(
   parameter int PID_WIDTH     = 4,
   parameter int PADDR_WIDTH   = 32,
   parameter int PLENGTH_WIDTH = 8,
   parameter int PDATA_WIDTH   = 4,
   parameter int OQ_DEPTH      = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [1:0]                     m_awvalid,
   output logic [1:0]                     m_awready,
   input  logic [2*PID_WIDTH-1:0]         m_awid,
   input  logic [2*PADDR_WIDTH-1:0]       m_awaddr,
   input  logic [2*PLENGTH_WIDTH-1:0]     m_awlen,
   input  logic [1:0]                     m_wvalid,
   output logic [1:0]                     m_wready,
   input  logic [2*8*PDATA_WIDTH-1:0]     m_wdata,
   input  logic [2*PDATA_WIDTH-1:0]       m_wstrb,
   input  logic [1:0]                     m_wlast,
   output logic [1:0]                     m_bvalid,
   input  logic [1:0]                     m_bready,
   output logic [2*PID_WIDTH-1:0]         m_bid,
   output logic [3:0]                     m_bresp,
   output logic                           s_awvalid,
   input  logic                           s_awready,
   output logic [PID_WIDTH:0]             s_awid,
   output logic [PADDR_WIDTH-1:0]         s_awaddr,
   output logic [PLENGTH_WIDTH-1:0]       s_awlen,
   output logic                           s_wvalid,
   input  logic                           s_wready,
   output logic [8*PDATA_WIDTH-1:0]       s_wdata,
   output logic [PDATA_WIDTH-1:0]         s_wstrb,
   output logic                           s_wlast,
   input  logic                           s_bvalid,
   output logic                           s_bready,
   input  logic [PID_WIDTH:0]             s_bid,
   input  logic [1:0]                     s_bresp,
   output logic                           len_err
);
   localparam int WW = 8 * PDATA_WIDTH;
   localparam int PW = $clog2(OQ_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(OQ_DEPTH);

   // Every channel follows valid/ready: a transfer happens on the rising edge where both are high.
   typedef enum logic {S_IDLE, S_GRANT} aw_state_t;
   aw_state_t state, state_nxt;

   logic          grant_idx, last_served, pick_idx, head, b_sel;
   logic          aw_hs, push, pop, q_full, q_empty;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic [OQ_DEPTH-1:0] idx_mem;

   logic [PID_WIDTH-1:0]     aw_id   [2];
   logic [PADDR_WIDTH-1:0]   aw_addr [2];
   logic [PLENGTH_WIDTH-1:0] aw_len  [2];
   logic [WW-1:0]            w_data  [2];
   logic [PDATA_WIDTH-1:0]   w_strb  [2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         aw_id[i]   = m_awid[i*PID_WIDTH +: PID_WIDTH];
         aw_addr[i] = m_awaddr[i*PADDR_WIDTH +: PADDR_WIDTH];
         aw_len[i]  = m_awlen[i*PLENGTH_WIDTH +: PLENGTH_WIDTH];
         w_data[i]  = m_wdata[i*WW +: WW];
         w_strb[i]  = m_wstrb[i*PDATA_WIDTH +: PDATA_WIDTH];
      end
   end

   assign q_full   = (count == FULL_CNT);
   assign q_empty  = (count == '0);
   assign head     = idx_mem[rd_ptr];
   // Tie goes to the master that was not served last.
   assign pick_idx = (&m_awvalid) ? ~last_served : m_awvalid[1];
   assign aw_hs    = s_awvalid & s_awready;
   assign push     = aw_hs;
   assign pop      = s_wvalid & s_wready & s_wlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if ((|m_awvalid) && !q_full) state_nxt = S_GRANT;
         S_GRANT: if (aw_hs) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      s_awvalid = 1'b0;
      m_awready = '0;
      s_awid    = {grant_idx, aw_id[grant_idx]};
      s_awaddr  = aw_addr[grant_idx];
      s_awlen   = aw_len[grant_idx];
      if (state == S_GRANT) begin
         s_awvalid            = m_awvalid[grant_idx];
         m_awready[grant_idx] = s_awready;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_idx   <= 1'b0;
         last_served <= 1'b1;
      end else begin
         if (state == S_IDLE && state_nxt == S_GRANT) grant_idx <= pick_idx;
         if (aw_hs) last_served <= grant_idx;
      end
   end

   // Order queue of granted master indices; the head owns the W channel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         idx_mem <= '0;
      end else begin
         if (push) begin
            idx_mem[wr_ptr] <= grant_idx;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_comb begin
      s_wvalid = 1'b0;
      m_wready = '0;
      s_wdata  = w_data[head];
      s_wstrb  = w_strb[head];
      s_wlast  = m_wlast[head];
      if (!q_empty) begin
         s_wvalid       = m_wvalid[head];
         m_wready[head] = s_wready;
      end
   end

   assign b_sel = s_bid[PID_WIDTH];

   always_comb begin
      m_bvalid        = '0;
      m_bvalid[b_sel] = s_bvalid;
      s_bready        = m_bready[b_sel];
      m_bid           = {2{s_bid[PID_WIDTH-1:0]}};
      m_bresp         = {2{s_bresp}};
   end

`ifdef ARB_LEN_CHECK_EN
   logic [PLENGTH_WIDTH-1:0] len_mem [OQ_DEPTH];
   logic [PLENGTH_WIDTH:0]   beat_cnt, head_len;
   logic                     w_hs;

   assign w_hs     = s_wvalid & s_wready;
   assign head_len = {1'b0, len_mem[rd_ptr]};

   // Flag a last beat at the wrong count, or a non-last beat where the burst should end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < OQ_DEPTH; i++) len_mem[i] <= '0;
         beat_cnt <= '0;
         len_err  <= 1'b0;
      end else begin
         if (push) len_mem[wr_ptr] <= s_awlen;
         if (w_hs) begin
            if (s_wlast) begin
               if (beat_cnt != head_len) len_err <= 1'b1;
               beat_cnt <= '0;
            end else begin
               if (beat_cnt == head_len) len_err <= 1'b1;
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign len_err = 1'b0;
`endif

endmodule
